// File: rtl/latch_port_bank_pkg.sv
// Shared MSX definitions used by the latch port bank: channel limits,
// device type encoding and a parameter range helper.
package latch_port_bank_pkg;

    localparam int LATCH_MAX_CHANNELS  = 8;
    localparam int LATCH_MAX_WIDTH     = 8;
    localparam int LATCH_MAX_PULSE_LEN = 255;

    typedef enum logic [2:0] {
        DEV_NONE          = 3'd0,
        DEV_MEMORY_MAPPER = 3'd1,
        DEV_LATCH_PORT    = 3'd2,
        DEV_SOUND         = 3'd3,
        DEV_VIDEO         = 3'd4
    } device_t;

    // True when v lies within [lo, hi].
    function automatic bit in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/latch_port_bank_chan.sv
// One latch channel: write-edge detect, stored value, optional pulse
// timer and sticky update flag.
module latch_port_chan
    import latch_port_bank_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit PULSE     = 1'b0,
    parameter int PULSE_LEN = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_term_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             upd_ack_i,
    output logic [WIDTH-1:0] value_o,
    output logic             upd_o
);

    localparam logic [7:0] LEN_C = 8'(PULSE_LEN);

    logic             edge_q,  edge_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [7:0]       cnt_q,   cnt_d;
    logic             upd_q,   upd_d;
    logic             wr_evt_s;

    // The edge register holds the previous write term; it resets high so a
    // term already asserted at reset release is not seen as a new write.
    assign wr_evt_s = wr_term_i & ~edge_q;

    // Next-state: pulse countdown first, then a write event overrides it.
    always_comb begin
        edge_d  = wr_term_i;
        value_d = value_q;
        cnt_d   = cnt_q;
        upd_d   = upd_q;
        if (PULSE && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
                value_d = '0;
            end else begin
                value_d = value_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
        if (wr_evt_s) begin
            value_d = data_i;
            upd_d   = 1'b1;
            if (PULSE) begin
                cnt_d = LEN_C;
            end else begin
                cnt_d = 8'd0;
            end
        end else if (upd_ack_i) begin
            upd_d = 1'b0;
        end else begin
            upd_d = upd_q;
        end
    end

    // Channel state registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_q  <= 1'b1;
            value_q <= '0;
            cnt_q   <= 8'd0;
            upd_q   <= 1'b0;
        end else begin
            edge_q  <= edge_d;
            value_q <= value_d;
            cnt_q   <= cnt_d;
            upd_q   <= upd_d;
        end
    end

    assign value_o = value_q;
    assign upd_o   = upd_q;

endmodule

// File: rtl/latch_port_bank.sv
// Bank of CPU-writable IO latch channels with combinational readback and
// a device-bus selected output toward the memory mapper.
module latch_port_bank
    import latch_port_bank_pkg::*;
#(
    parameter int                  CHANNELS   = 3,
    parameter int                  WIDTH      = 8,
    parameter logic [CHANNELS-1:0] PULSE_MODE = '0,
    parameter int                  PULSE_LEN  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req,
    input  logic                iorq,
    input  logic                m1,
    input  logic                wr,
    input  logic                rd,
    input  logic [7:0]          data_in,
    input  logic [CHANNELS-1:0] sel,
    output logic [7:0]          rd_data,
    output logic                rd_hit,
    input  logic                dev_sel,
    input  logic [2:0]          dev_num,
    output logic [WIDTH-1:0]    data_to_mapper,
    output logic [CHANNELS-1:0] upd,
    input  logic [CHANNELS-1:0] upd_ack
);

    if (!in_range(CHANNELS, 1, LATCH_MAX_CHANNELS)) begin : g_bad_channels
        $error("latch_port_bank: CHANNELS out of range 1..8");
    end
    if (!in_range(WIDTH, 1, LATCH_MAX_WIDTH)) begin : g_bad_width
        $error("latch_port_bank: WIDTH out of range 1..8");
    end
    if (!in_range(PULSE_LEN, 1, LATCH_MAX_PULSE_LEN)) begin : g_bad_pulse_len
        $error("latch_port_bank: PULSE_LEN out of range 1..255");
    end

    logic             io_en_s;
    logic             wr_base_s;
    logic             rd_base_s;
    logic [WIDTH-1:0] value_s [CHANNELS];

    assign io_en_s   = iorq & ~m1;
    assign wr_base_s = req & io_en_s & wr;
    assign rd_base_s = req & io_en_s & rd;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        latch_port_chan #(
            .WIDTH     (WIDTH),
            .PULSE     (PULSE_MODE[gi]),
            .PULSE_LEN (PULSE_LEN)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .wr_term_i (wr_base_s & sel[gi]),
            .data_i    (data_in[WIDTH-1:0]),
            .upd_ack_i (upd_ack[gi]),
            .value_o   (value_s[gi]),
            .upd_o     (upd[gi])
        );
    end

    // Readback mux: scan high to low so the lowest selected index wins.
    always_comb begin
        rd_data = 8'hFF;
        rd_hit  = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (rd_base_s && sel[i]) begin
                rd_data            = 8'h00;
                rd_data[WIDTH-1:0] = value_s[i];
                rd_hit             = 1'b1;
            end else begin
                rd_hit = rd_hit;
            end
        end
    end

    // Mapper output: selected channel value, all ones for no/invalid channel.
    always_comb begin
        data_to_mapper = '1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (dev_sel && (dev_num == 3'(i))) begin
                data_to_mapper = value_s[i];
            end else begin
                data_to_mapper = data_to_mapper;
            end
        end
    end

endmodule
